// File: rtl/farrow_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// farrow_pkg : mode encoding, pipeline latency and Q-format constant helpers
// Revision   : 1.0
// ============================================================================
package farrow_pkg;

  typedef enum logic {
    MODE_LINEAR = 1'b0,
    MODE_CUBIC  = 1'b1
  } mode_e;

  localparam int LATENCY = 4;

  function automatic int calc_one(input int dec);
    return 1 << dec;
  endfunction

  // Each fraction is rounded to nearest: floor(ONE/k + 1/2) = (2*ONE + k) / (2*k)
  function automatic int calc_half(input int dec);
    return ((2 << dec) + 2) / 4;
  endfunction

  function automatic int calc_third(input int dec);
    return ((2 << dec) + 3) / 6;
  endfunction

  function automatic int calc_sixth(input int dec);
    return ((2 << dec) + 6) / 12;
  endfunction

endpackage
`default_nettype wire

// File: rtl/farrow_coef.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// farrow_coef : registered Farrow coefficients c0..c3 from mu (linear or cubic)
// Revision    : 1.0
// ============================================================================
module farrow_coef import farrow_pkg::*; #(
  parameter int W         = 17,
  parameter int DEC_WIDTH = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] mu,
  input  logic                mode,
  output logic signed [W-1:0] c0,
  output logic signed [W-1:0] c1,
  output logic signed [W-1:0] c2,
  output logic signed [W-1:0] c3
);

  localparam int W2 = 2 * W;
  localparam logic signed [W-1:0] K_ONE   = W'(calc_one(DEC_WIDTH));
  localparam logic signed [W-1:0] K_TWO   = W'(2 * calc_one(DEC_WIDTH));
  localparam logic signed [W-1:0] K_HALF  = W'(calc_half(DEC_WIDTH));
  localparam logic signed [W-1:0] K_SIXTH = W'(calc_sixth(DEC_WIDTH));

  // Full-width product, floor-shifted back to the Q format
  function automatic logic signed [W-1:0] qmul(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
    logic signed [W2-1:0] p;
    p = W2'(a) * W2'(b);
    return W'(p >>> DEC_WIDTH);
  endfunction

  logic signed [W-1:0] mp1, mm1, mm2, sq_m1;
  logic signed [W-1:0] n0, n1, n2, n3;

  always_comb begin
    mp1   = mu + K_ONE;
    mm1   = mu - K_ONE;
    mm2   = mu - K_TWO;
    sq_m1 = qmul(mm1, mp1);
    n0    = '0;
    n1    = '0;
    n2    = '0;
    n3    = '0;
    if (mode == MODE_CUBIC) begin
      n0 =  qmul(qmul(mu, sq_m1), K_SIXTH);
      n1 = -qmul(qmul(qmul(mu, mp1), mm2), K_HALF);
      n2 =  qmul(qmul(sq_m1, mm2), K_HALF);
      n3 = -qmul(qmul(qmul(mu, mm1), mm2), K_SIXTH);
    end else begin
      n1 = mu;
      n2 = K_ONE - mu;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c0 <= '0;
      c1 <= '0;
      c2 <= '0;
      c3 <= '0;
    end else begin
      c0 <= n0;
      c1 <= n1;
      c2 <= n2;
      c3 <= n3;
    end
  end

endmodule
`default_nettype wire

// File: rtl/farrow_interp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// farrow_interp : I/Q Farrow interpolator (linear / cubic Lagrange), 4-stage pipe
// Revision      : 1.0
// ============================================================================
module farrow_interp import farrow_pkg::*; #(
  parameter int SYM_WIDTH = 1,
  parameter int INT_WIDTH = 2,
  parameter int DEC_WIDTH = 14
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  input  logic signed [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0] in_i,
  input  logic signed [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0] in_q,
  input  logic                                          strobe,
  input  logic signed [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0] mu,
  input  logic                                          mode,
  output logic                                          out_valid,
  output logic signed [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0] out_i,
  output logic signed [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0] out_q,
  output logic                                          sat,
  output logic                                          ovf
);

  localparam int W  = SYM_WIDTH + INT_WIDTH + DEC_WIDTH;
  localparam int W2 = 2 * W;
  localparam int AW = W + 2;
  localparam logic signed [W-1:0]  K_ONE   = W'(calc_one(DEC_WIDTH));
  localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (W - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(1 << (W - 1)));

  function automatic logic signed [AW-1:0] tap_mul(input logic signed [W-1:0] c,
                                                   input logic signed [W-1:0] d);
    logic signed [W2-1:0] p;
    p = W2'(c) * W2'(d);
    return AW'(p >>> DEC_WIDTH);
  endfunction

  // Channel index 0 = I, 1 = Q; tap index 0 = newest
  logic signed [W-1:0] smp [2];
  logic signed [W-1:0] tap [2][4];
  logic [2:0]          fill;
  logic                accept;
  logic signed [W-1:0] mu_clamped;

  assign smp[0] = in_i;
  assign smp[1] = in_q;
  assign accept = in_valid && strobe && (fill >= 3'd3);

  always_comb begin
    mu_clamped = mu;
    if (mu[W-1])
      mu_clamped = '0;
    else if (mu > K_ONE)
      mu_clamped = K_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill <= '0;
      for (int ch = 0; ch < 2; ch++)
        for (int k = 0; k < 4; k++)
          tap[ch][k] <= '0;
    end else if (in_valid) begin
      if (fill != 3'd4)
        fill <= fill + 3'd1;
      for (int ch = 0; ch < 2; ch++) begin
        tap[ch][0] <= smp[ch];
        for (int k = 1; k < 4; k++)
          tap[ch][k] <= tap[ch][k-1];
      end
    end
  end

  // Stage 1: capture the window that includes the current sample
  logic                s1_valid, s1_mode;
  logic signed [W-1:0] s1_mu;
  logic signed [W-1:0] s1_tap [2][4];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_mu    <= '0;
      for (int ch = 0; ch < 2; ch++)
        for (int k = 0; k < 4; k++)
          s1_tap[ch][k] <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_mode <= mode;
        s1_mu   <= mu_clamped;
        for (int ch = 0; ch < 2; ch++) begin
          s1_tap[ch][0] <= smp[ch];
          for (int k = 1; k < 4; k++)
            s1_tap[ch][k] <= tap[ch][k-1];
        end
      end
    end
  end

  // Stage 2: coefficients, taps follow alongside
  logic signed [W-1:0] coef [4];
  logic                s2_valid;
  logic signed [W-1:0] s2_tap [2][4];

  farrow_coef #(
    .W         (W),
    .DEC_WIDTH (DEC_WIDTH)
  ) u_coef (
    .clk  (clk),
    .rst  (rst),
    .mu   (s1_mu),
    .mode (s1_mode),
    .c0   (coef[0]),
    .c1   (coef[1]),
    .c2   (coef[2]),
    .c3   (coef[3])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      for (int ch = 0; ch < 2; ch++)
        for (int k = 0; k < 4; k++)
          s2_tap[ch][k] <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid)
        s2_tap <= s1_tap;
    end
  end

  // Stage 3: products
  logic                 s3_valid;
  logic signed [AW-1:0] prod [2][4];

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      for (int ch = 0; ch < 2; ch++)
        for (int k = 0; k < 4; k++)
          prod[ch][k] <= '0;
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid)
        for (int ch = 0; ch < 2; ch++)
          for (int k = 0; k < 4; k++)
            prod[ch][k] <= tap_mul(coef[k], s2_tap[ch][k]);
    end
  end

  // Stage 4: accumulate with headroom, then clip to the output word
  logic signed [AW-1:0] sum [2];
  logic signed [W-1:0]  res [2];
  logic [1:0]           clip;

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      sum[ch]  = prod[ch][0] + prod[ch][1] + prod[ch][2] + prod[ch][3];
      res[ch]  = W'(sum[ch]);
      clip[ch] = 1'b0;
      if (sum[ch] > SAT_MAX) begin
        res[ch]  = W'(SAT_MAX);
        clip[ch] = 1'b1;
      end else if (sum[ch] < SAT_MIN) begin
        res[ch]  = W'(SAT_MIN);
        clip[ch] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      sat       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= s3_valid;
      sat       <= s3_valid && (|clip);
      if (s3_valid) begin
        out_i <= res[0];
        out_q <= res[1];
        if (|clip)
          ovf <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/farrow_interp.md
FARROW_INTERP -- requirements
Module: farrow_interp

Interface
REQ-001 The block SHALL have parameter SYM_WIDTH, default 1, meaning sign bits of every fixed-point word.
REQ-002 The block SHALL have parameter INT_WIDTH, default 2, meaning integer bits.
REQ-003 The block SHALL have parameter DEC_WIDTH, default 14, meaning fraction bits; W = SYM_WIDTH+INT_WIDTH+DEC_WIDTH and ONE = 2^DEC_WIDTH.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_i/in_q carry a new sample this cycle.
REQ-007 The block SHALL have ports in_i and in_q, input, W bits signed: the I and Q samples.
REQ-008 The block SHALL have port strobe, input, 1 bit: request an interpolant on this sample; it is ignored unless in_valid=1.
REQ-009 The block SHALL have port mu, input, W bits signed: the fractional interval, sampled with strobe.
REQ-010 The block SHALL have port mode, input, 1 bit: 0 = linear, 1 = cubic Lagrange; it is sampled with strobe.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a one-cycle pulse per interpolant.
REQ-012 The block SHALL have ports out_i and out_q, output, W bits signed: the interpolants.
REQ-013 The block SHALL have port sat, output, 1 bit: pulses with out_valid when either channel saturated.
REQ-014 The block SHALL have port ovf, output, 1 bit: sticky saturation flag.

Function
REQ-015 Per channel, the block SHALL keep a 4-deep tap buffer d0 (newest) to d3 (oldest) that shifts on in_valid; an accepted strobe uses the buffer including the current sample.
REQ-016 A fill counter SHALL saturate at 4; a strobe is accepted only if the count, including the current sample, is 4, and a strobe with fewer samples is silently dropped.
REQ-017 On acceptance, stage 1 SHALL register the taps, mode and mu, with mu clamped to [0, ONE].
REQ-018 Stage 2 (cubic) SHALL compute the coefficients as follows.
- c0 = mu(mu^2-1)/6
- c1 = -mu(mu+1)(mu-2)/2
- c2 = (mu-1)(mu+1)(mu-2)/2
- c3 = -mu(mu-1)(mu-2)/6
REQ-019 Stage 2 (linear) SHALL compute c1 = mu, c2 = ONE-mu and c0 = c3 = 0.
REQ-020 Stage 3 SHALL form the products ck*dk.
REQ-021 Stage 4 SHALL sum the products and saturate the result.
REQ-022 The pipeline SHALL be fully pipelined: out_valid is asserted exactly 4 cycles after the accepting cycle, with throughput of one interpolant per cycle.
REQ-023 Every product SHALL be formed at full 2W width, then arithmetically shifted right by DEC_WIDTH (floor); the 1/6, 1/2 and 1/3 constants are round-to-nearest in DEC_WIDTH bits.
REQ-024 Accumulation SHALL be done in W+2 bits, then saturated to [-2^(W-1), 2^(W-1)-1].
REQ-025 At mu=0 the output SHALL equal d2, and at mu=ONE the output SHALL equal d1, exactly in linear mode and to within ±1 LSB in cubic mode.
REQ-026 out_i and out_q SHALL hold their last value while out_valid=0.
REQ-027 ovf SHALL be set when sat=1 and cleared only by rst.
REQ-028 A new mode or mu presented on back-to-back strobes SHALL affect only its own interpolant.

Reset
REQ-029 When rst=1, the block SHALL clear the taps, the fill counter and every stage-valid bit.
REQ-030 When rst=1, the block SHALL drive out_valid, out_i, out_q, sat and ovf to 0 on the next edge.
REQ-031 Interpolants in flight at reset SHALL be discarded, and the buffer SHALL refill with 4 samples before the next strobe is accepted.

Structure
REQ-032 The shared package farrow_pkg SHALL hold the following.
- Mode encoding: MODE_LINEAR = 0, MODE_CUBIC = 1.
- Pipeline latency constant: 4.
- Functions that derive ONE, 1/2, 1/3 and 1/6 from DEC_WIDTH.
REQ-033 The coefficient generator SHALL be a sub-module farrow_coef, shared by I and Q, that takes mu and mode and registers c0 to c3.

Verification
REQ-034 Cubic ramp: with DEC_WIDTH=14, feed I=0,1000,2000,3000 and strobe on the 4th sample with mu=0 -> out_i=1000 after 4 cycles; the same stimulus with mu=8192 -> out_i=1500 ±1.
REQ-035 Linear: with d2=2000, d1=4000, mode=0 and mu=4096 -> out_i=2500, sat=0.
REQ-036 Early strobe: strobe on the 3rd sample after reset -> no out_valid; strobe on the 4th sample -> out_valid 4 cycles later.
REQ-037 Saturation: with d3=d0=-65536, d2=d1=65535, cubic, mu=8192 -> out_i=65535, sat pulses, ovf stays 1.
REQ-038 Clamp and throughput: mu=20000 -> output equals d1; strobes on 6 consecutive samples -> 6 consecutive out_valid pulses in order.
REQ-039 Reset mid-pipe: assert rst 2 cycles after a strobe -> no out_valid and all outputs 0 until refill.
